// File: rtl/red_pitaya_pll_drp.sv
// DRP master for the system PLL: runs read-modify-write commands with the PLL held in reset,
// then releases reset and waits for lock, reporting DRDY or lock timeouts through err.
module red_pitaya_pll_drp #(
  parameter int unsigned RST_HOLD     = 4,
  parameter int unsigned DRDY_TIMEOUT = 255,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_mask,
  input  logic [15:0] cmd_data,
  input  logic        cmd_last,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  localparam int unsigned MaxDrdyHold = (DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD;
  localparam int unsigned MaxCnt      = (LOCK_TIMEOUT > MaxDrdyHold) ? LOCK_TIMEOUT : MaxDrdyHold;
  localparam int unsigned CntW        = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] HoldLast = CntW'(RST_HOLD - 1);
  localparam logic [CntW-1:0] DrdyLast = CntW'(DRDY_TIMEOUT - 1);
  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] ErrNone = 2'd0;
  localparam logic [1:0] ErrDrdy = 2'd1;
  localparam logic [1:0] ErrLock = 2'd2;

  typedef enum logic [3:0] {
    StIdle, StHold, StRd, StWaitRd, StWr, StWaitWr, StNext, StRel, StWaitLock
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     mask_q;
  logic [15:0]     data_q;
  logic            last_q;
  logic [1:0]      lock_sync_q;
  logic            accept;

  assign accept = cmd_valid & cmd_ready;

  // All outputs are registered; each transition sets the outputs of the state being entered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mask_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      lock_sync_q <= '0;
      cmd_ready   <= 1'b1;
      drp_daddr   <= '0;
      drp_den     <= 1'b0;
      drp_dwe     <= 1'b0;
      drp_di      <= '0;
      pll_rst     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= ErrNone;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked};
      drp_den     <= 1'b0;
      drp_dwe     <= 1'b0;
      done        <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            drp_daddr <= cmd_addr;
            mask_q    <= cmd_mask;
            data_q    <= cmd_data;
            last_q    <= cmd_last;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            err       <= ErrNone;
            pll_rst   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StHold;
          end
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            drp_den <= 1'b1;
            state_q <= StRd;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRd: begin
          cnt_q   <= '0;
          state_q <= StWaitRd;
        end
        StWaitRd: begin
          // A DRDY coinciding with the terminal count still wins.
          if (drp_drdy) begin
            drp_di  <= (drp_do & mask_q) | (data_q & ~mask_q);
            drp_den <= 1'b1;
            drp_dwe <= 1'b1;
            state_q <= StWr;
          end else if (cnt_q == DrdyLast) begin
            err       <= ErrDrdy;
            pll_rst   <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWr: begin
          cnt_q   <= '0;
          state_q <= StWaitWr;
        end
        StWaitWr: begin
          if (drp_drdy) begin
            if (last_q) begin
              pll_rst <= 1'b0;
              state_q <= StRel;
            end else begin
              cmd_ready <= 1'b1;
              state_q   <= StNext;
            end
          end else if (cnt_q == DrdyLast) begin
            err       <= ErrDrdy;
            pll_rst   <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StNext: begin
          if (accept) begin
            drp_daddr <= cmd_addr;
            mask_q    <= cmd_mask;
            data_q    <= cmd_data;
            last_q    <= cmd_last;
            cmd_ready <= 1'b0;
            drp_den   <= 1'b1;
            state_q   <= StRd;
          end
        end
        StRel: begin
          cnt_q   <= '0;
          state_q <= StWaitLock;
        end
        StWaitLock: begin
          if (lock_sync_q[1]) begin
            err       <= ErrNone;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end else if (cnt_q == LockLast) begin
            err       <= ErrLock;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
